// File: rtl/icache_req_scheduler_pkg.sv
// Shared types and constants for the ICache request scheduler.
package icache_req_scheduler_pkg;

    // Default ICache line size in bytes and the 4KB page offset width.
    localparam int ICACHE_LINE_BYTES = 16;
    localparam int PAGE_OFFSET_BITS  = 12;

    // Scheduler states: idle, waiting on a demand access, waiting on a prefetch.
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEMAND_WAIT = 2'd1,
        PF_WAIT     = 2'd2
    } icache_sched_state_t;

    // Plain vector encodings of the states, used by the FSM register.
    localparam logic [1:0] ST_IDLE        = IDLE;
    localparam logic [1:0] ST_DEMAND_WAIT = DEMAND_WAIT;
    localparam logic [1:0] ST_PF_WAIT     = PF_WAIT;

endpackage

// File: rtl/icache_req_scheduler_if.sv
// Fetch-side and ICache-side signal bundle of the request scheduler.
// The master modport is the scheduler itself; slave is its environment.
interface icache_req_scheduler_if #(
    parameter int VADDR_W = 40,
    parameter int CNT_W   = 16
);
    logic               fetch_req_valid;
    logic [VADDR_W-1:0] fetch_req_vaddr;
    logic               fetch_req_ready;
    logic               fetch_flush;
    logic               pf_enable;
    logic               icache_req_ready;
    logic               icache_req_valid;
    logic [VADDR_W-1:0] icache_req_vaddr;
    logic               icache_req_kill;
    logic               icache_resp_valid;
    logic               icache_resp_xcpt;
    logic               fetch_resp_valid;
    logic               fetch_resp_xcpt;
    logic [CNT_W-1:0]   pf_issued_cnt;

    modport master (
        input  fetch_req_valid, fetch_req_vaddr, fetch_flush, pf_enable,
        input  icache_req_ready, icache_resp_valid, icache_resp_xcpt,
        output fetch_req_ready, icache_req_valid, icache_req_vaddr,
        output icache_req_kill, fetch_resp_valid, fetch_resp_xcpt,
        output pf_issued_cnt
    );

    modport slave (
        output fetch_req_valid, fetch_req_vaddr, fetch_flush, pf_enable,
        output icache_req_ready, icache_resp_valid, icache_resp_xcpt,
        input  fetch_req_ready, icache_req_valid, icache_req_vaddr,
        input  icache_req_kill, fetch_resp_valid, fetch_resp_xcpt,
        input  pf_issued_cnt
    );
endinterface

// File: rtl/icache_req_scheduler_sat_counter.sv
// Saturating up-counter used for the prefetch-issue PMU event.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    // Count up on each increment request and stick at all-ones.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/icache_req_scheduler.sv
// Sequences demand fetches and next-line prefetches onto the single
// ICache request port, tracks the one outstanding access, kills it on
// flush or demand pre-emption, and forwards only demand responses.
module icache_req_scheduler
    import icache_req_scheduler_pkg::*;
#(
    parameter int VADDR_W    = 40,
    parameter int LINE_BYTES = ICACHE_LINE_BYTES,
    parameter int CNT_W      = 16
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    icache_req_scheduler_if.master bus
);

    localparam int LOFF = $clog2(LINE_BYTES);
    localparam logic [VADDR_W-LOFF-1:0] LINE_ONE = (VADDR_W-LOFF)'(1);

    logic [1:0]              state_q, state_d;
    logic                    pf_pending_q, pf_pending_d;
    logic [VADDR_W-1:LOFF]   pf_line_q, pf_line_d;
    logic [VADDR_W-1:LOFF]   last_line_q, last_line_d;
    logic [VADDR_W-LOFF-1:0] next_line;
    logic                    next_line_in_page;
    logic                    completion;
    logic                    pf_inc;
    logic [CNT_W-1:0]        pf_count;

    assign next_line         = last_line_q + LINE_ONE;
    assign next_line_in_page = !(&last_line_q[PAGE_OFFSET_BITS-1:LOFF]);
    assign completion        = bus.icache_resp_valid | bus.icache_resp_xcpt;

    // Next-state, request issue and response routing for the single outstanding access.
    always_comb begin
        state_d              = state_q;
        pf_pending_d         = pf_pending_q;
        pf_line_d            = pf_line_q;
        last_line_d          = last_line_q;
        pf_inc               = 1'b0;
        bus.fetch_req_ready  = 1'b0;
        bus.icache_req_valid = 1'b0;
        bus.icache_req_vaddr = '0;
        bus.icache_req_kill  = 1'b0;
        bus.fetch_resp_valid = 1'b0;
        bus.fetch_resp_xcpt  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bus.fetch_req_ready = bus.icache_req_ready & ~bus.fetch_flush;
                if (bus.fetch_req_valid && bus.fetch_req_ready) begin
                    bus.icache_req_valid = 1'b1;
                    bus.icache_req_vaddr = bus.fetch_req_vaddr;
                    last_line_d          = bus.fetch_req_vaddr[VADDR_W-1:LOFF];
                    pf_pending_d         = 1'b0;
                    state_d              = ST_DEMAND_WAIT;
                end else if (pf_pending_q && bus.pf_enable && bus.icache_req_ready
                             && !bus.fetch_flush) begin
                    bus.icache_req_valid = 1'b1;
                    bus.icache_req_vaddr = {pf_line_q, {LOFF{1'b0}}};
                    pf_pending_d         = 1'b0;
                    pf_inc               = 1'b1;
                    state_d              = ST_PF_WAIT;
                end
                if (bus.fetch_flush) begin
                    pf_pending_d = 1'b0;
                end
            end

            ST_DEMAND_WAIT: begin
                if (bus.fetch_flush) begin
                    bus.icache_req_kill = 1'b1;
                    pf_pending_d        = 1'b0;
                    state_d             = ST_IDLE;
                end else if (completion) begin
                    bus.fetch_resp_valid = 1'b1;
                    bus.fetch_resp_xcpt  = bus.icache_resp_xcpt;
                    state_d              = ST_IDLE;
                    if (!bus.icache_resp_xcpt && bus.pf_enable && next_line_in_page) begin
                        pf_pending_d = 1'b1;
                        pf_line_d    = next_line;
                    end
                end
            end

            ST_PF_WAIT: begin
                if (bus.fetch_flush) begin
                    bus.icache_req_kill = 1'b1;
                    pf_pending_d        = 1'b0;
                    state_d             = ST_IDLE;
                end else if (completion) begin
                    state_d = ST_IDLE;
                end else if (bus.fetch_req_valid) begin
                    bus.icache_req_kill = 1'b1;
                    state_d             = ST_IDLE;
                end
            end

            default: begin
                state_d      = ST_IDLE;
                pf_pending_d = 1'b0;
            end
        endcase
    end

    // State, pending prefetch and last demand line registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= ST_IDLE;
            pf_pending_q <= 1'b0;
            pf_line_q    <= '0;
            last_line_q  <= '0;
        end else begin
            state_q      <= state_d;
            pf_pending_q <= pf_pending_d;
            pf_line_q    <= pf_line_d;
            last_line_q  <= last_line_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_pf_counter (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .inc    (pf_inc),
        .count  (pf_count)
    );

    assign bus.pf_issued_cnt = pf_count;

endmodule
